writeback_stage_pipelined: RTL

- Registered, handshaked successor to the combinational write-back stage. Sits between the MEM stage and the register file/fetch.
- Holds one instruction in a WB slot and waits for variable-latency load responses. Performs sub-word load alignment and sign/zero extension.
- Selects write-back data and computes next PC and redirect. Provides a flush path and a retired-instruction counter.

---
 rtl/writeback_stage_pipelined.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/writeback_stage_pipelined.sv
// Registered write-back stage: one-instruction slot, variable-latency load wait,
// sub-word load alignment, next-PC/redirect generation, flush and retire counter.
//
// state    | meaning
// EMPTY    | no instruction in the slot
// HOLD     | non-load in the slot, retires next cycle
// WAIT_MEM | load in the slot, waiting for its memory response
module writeback_stage_pipelined #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int RWIDTH  = 5,
    parameter int CNTW    = 64,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic [RWIDTH-1:0] rd_i,
    input  logic              regwren_i,
    input  logic [1:0]        wbsel_i,
    input  logic [2:0]        funct3_i,
    input  logic              brtaken_i,
    input  logic              flush_i,
    input  logic              mem_rsp_valid_i,
    input  logic [DWIDTH-1:0] mem_rsp_data_i,
    output logic              rd_wren_o,
    output logic [RWIDTH-1:0] rd_addr_o,
    output logic [DWIDTH-1:0] writeback_data_o,
    output logic [AWIDTH-1:0] next_pc_o,
    output logic              redirect_o,
    output logic              misalign_o,
    output logic              retire_o,
    output logic [CNTW-1:0]   instret_o
);
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef enum logic [1:0] {EMPTY, HOLD, WAIT_MEM} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] alu_q, alu_d;
    logic [RWIDTH-1:0] rd_q, rd_d;
    logic              regwren_q, regwren_d;
    logic [1:0]        wbsel_q, wbsel_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              brtaken_q, brtaken_d;
    logic              discard_q, discard_d;
    logic [CNTW-1:0]   instret_q, instret_d;

    logic              retire_now, accept;
    logic [1:0]        offset;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DWIDTH-1:0] load_data, wb_data;
    logic              load_mis, misalign;
    logic [AWIDTH-1:0] pc_seq;

    // A flushed slot never retires, even if its response shows up that cycle.
    assign retire_now = !flush_i &&
                        ((state_q == HOLD) ||
                         (state_q == WAIT_MEM && mem_rsp_valid_i && !discard_q));
    assign in_ready_o = (state_q == EMPTY) || retire_now;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    assign offset   = alu_q[1:0];
    assign half_sel = offset[1] ? mem_rsp_data_i[31:16] : mem_rsp_data_i[15:0];

    always_comb begin
        byte_sel = mem_rsp_data_i[7:0];
        case (offset)
            2'd1:    byte_sel = mem_rsp_data_i[15:8];
            2'd2:    byte_sel = mem_rsp_data_i[23:16];
            2'd3:    byte_sel = mem_rsp_data_i[31:24];
            default: byte_sel = mem_rsp_data_i[7:0];
        endcase
    end

    always_comb begin
        load_data = mem_rsp_data_i;
        load_mis  = (offset != 2'd0);
        case (funct3_q)
            3'b000: begin
                load_data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
                load_mis  = 1'b0;
            end
            3'b100: begin
                load_data = {{(DWIDTH-8){1'b0}}, byte_sel};
                load_mis  = 1'b0;
            end
            3'b001: begin
                load_data = {{(DWIDTH-16){half_sel[15]}}, half_sel};
                load_mis  = offset[0];
            end
            3'b101: begin
                load_data = {{(DWIDTH-16){1'b0}}, half_sel};
                load_mis  = offset[0];
            end
            default: begin
                load_data = mem_rsp_data_i;
                load_mis  = (offset != 2'd0);
            end
        endcase
    end

    assign misalign = (wbsel_q == WB_MEM) && load_mis;
    assign pc_seq   = pc_q + AWIDTH'(PC_STEP);

    always_comb begin
        wb_data = alu_q;
        case (wbsel_q)
            WB_MEM:  wb_data = load_data;
            WB_PC:   wb_data = DWIDTH'(pc_seq);
            default: wb_data = alu_q;
        endcase
    end

    assign retire_o         = retire_now;
    assign rd_wren_o        = retire_now && regwren_q && (rd_q != '0) && !misalign;
    assign rd_addr_o        = rd_wren_o ? rd_q : '0;
    assign writeback_data_o = rd_wren_o ? wb_data : '0;
    assign next_pc_o        = retire_now ? (brtaken_q ? AWIDTH'(alu_q) : pc_seq) : '0;
    assign redirect_o       = retire_now && brtaken_q;
    assign misalign_o       = retire_now && misalign;
    assign instret_o        = instret_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        alu_d     = alu_q;
        rd_d      = rd_q;
        regwren_d = regwren_q;
        wbsel_d   = wbsel_q;
        funct3_d  = funct3_q;
        brtaken_d = brtaken_q;
        discard_d = discard_q;
        instret_d = instret_q;

        if (accept) begin
            pc_d      = pc_i;
            alu_d     = alu_res_i;
            rd_d      = rd_i;
            regwren_d = regwren_i;
            wbsel_d   = wbsel_i;
            funct3_d  = funct3_i;
            brtaken_d = brtaken_i;
        end

        if (flush_i)
            state_d = EMPTY;
        else if (accept)
            state_d = (wbsel_i == WB_MEM) ? WAIT_MEM : HOLD;
        else if (retire_now)
            state_d = EMPTY;

        // The response owed to a killed load must not satisfy a later load.
        if (mem_rsp_valid_i && discard_q)
            discard_d = 1'b0;
        if (flush_i && state_q == WAIT_MEM && !(mem_rsp_valid_i && !discard_q))
            discard_d = 1'b1;

        if (retire_now)
            instret_d = instret_q + CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= EMPTY;
            pc_q      <= '0;
            alu_q     <= '0;
            rd_q      <= '0;
            regwren_q <= 1'b0;
            wbsel_q   <= WB_ALU;
            funct3_q  <= '0;
            brtaken_q <= 1'b0;
            discard_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            alu_q     <= alu_d;
            rd_q      <= rd_d;
            regwren_q <= regwren_d;
            wbsel_q   <= wbsel_d;
            funct3_q  <= funct3_d;
            brtaken_q <= brtaken_d;
            discard_q <= discard_d;
            instret_q <= instret_d;
        end
    end
endmodule
